ram_16x8_ctrl: RTL and testbench

User-side controller and storage for the 16x8 RAM demo. It debounces the board push-buttons and holds a 16-entry x 8-bit register RAM. It sequences view, auto-scan and fill operations, and presents the current address, mode and data word as the 16-bit hex value `x` consumed by the four-digit seven-segment display driver directly downstream.

---
 rtl/ram_16x8_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ram_16x8_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_16x8_ctrl.sv
// 16x8 register RAM with debounced button control and a hex display word.
// Modes: VIEW (browse/write), SCAN (auto address step), FILL (write all).
module ram_16x8_ctrl #(
  parameter int DB_BITS   = 20,
  parameter int SCAN_BITS = 26
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  sw,
  input  logic        btn_wr,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_mode,
  input  logic        btn_fill,
  output logic [15:0] x,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_VIEW = 2'd0,
    S_SCAN = 2'd1,
    S_FILL = 2'd2
  } state_t;

  localparam int NB = 5;

  logic [NB-1:0]      w_btn;
  logic [NB-1:0]      r_s1;
  logic [NB-1:0]      r_s2;
  logic [NB-1:0]      r_st;
  logic [NB-1:0]      r_pls;
  logic [DB_BITS-1:0] r_cnt [NB];

  assign w_btn = {btn_fill, btn_mode, btn_dec, btn_inc, btn_wr};

  // Pulse is raised together with the stable 0->1 update.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_st  <= '0;
      r_pls <= '0;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      for (int i = 0; i < NB; i++) begin
        r_pls[i] <= 1'b0;
        if (r_s2[i] != r_st[i]) begin
          if (&r_cnt[i]) begin
            r_st[i]  <= r_s2[i];
            r_cnt[i] <= '0;
            r_pls[i] <= r_s2[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + DB_BITS'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  logic w_p_wr;
  logic w_p_inc;
  logic w_p_dec;
  logic w_p_mode;
  logic w_p_fill;

  assign w_p_wr   = r_pls[0];
  assign w_p_inc  = r_pls[1];
  assign w_p_dec  = r_pls[2];
  assign w_p_mode = r_pls[3];
  assign w_p_fill = r_pls[4];

  state_t               r_state;
  state_t               w_state_nx;
  logic [3:0]           r_addr;
  logic [3:0]           w_addr_nx;
  logic [SCAN_BITS-1:0] r_div;
  logic [SCAN_BITS-1:0] w_div_nx;
  logic [3:0]           r_fidx;
  logic [3:0]           w_fidx_nx;
  logic                 w_we;
  logic [3:0]           w_waddr;
  logic [7:0]           r_mem [16];
  logic [3:0]           w_mode;
  logic [15:0]          r_x;
  logic                 r_busy;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_VIEW;
      r_addr  <= '0;
      r_div   <= '0;
      r_fidx  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_div   <= w_div_nx;
      r_fidx  <= w_fidx_nx;
    end
  end

  // Only the highest-priority pulse acts: fill > mode > wr > inc > dec.
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_div_nx   = r_div;
    w_fidx_nx  = r_fidx;
    w_we       = 1'b0;
    w_waddr    = r_addr;
    unique case (r_state)
      S_VIEW: begin
        if (w_p_fill) begin
          w_state_nx = S_FILL;
          w_fidx_nx  = '0;
        end else if (w_p_mode) begin
          w_state_nx = S_SCAN;
          w_div_nx   = '0;
        end else if (w_p_wr) begin
          w_we = 1'b1;
        end else if (w_p_inc) begin
          w_addr_nx = r_addr + 4'd1;
        end else if (w_p_dec) begin
          w_addr_nx = r_addr - 4'd1;
        end
      end
      S_SCAN: begin
        w_div_nx = r_div + SCAN_BITS'(1);
        if (w_p_fill) begin
          w_state_nx = S_FILL;
          w_fidx_nx  = '0;
        end else if (w_p_mode) begin
          w_state_nx = S_VIEW;
        end else begin
          w_we = w_p_wr;
          if (&r_div) w_addr_nx = r_addr + 4'd1;
        end
      end
      S_FILL: begin
        w_we      = 1'b1;
        w_waddr   = r_fidx;
        w_fidx_nx = r_fidx + 4'd1;
        if (&r_fidx) w_state_nx = S_VIEW;
      end
      default: begin
        w_state_nx = S_VIEW;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[w_waddr] <= sw;
    end
  end

  always_comb begin
    w_mode = 4'h0;
    unique case (r_state)
      S_SCAN:  w_mode = 4'h5;
      S_FILL:  w_mode = 4'hF;
      default: w_mode = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_x    <= '0;
      r_busy <= 1'b0;
    end else begin
      r_x    <= {r_addr, w_mode, r_mem[r_addr]};
      r_busy <= (w_state_nx == S_FILL);
    end
  end

  assign x    = r_x;
  assign busy = r_busy;

endmodule

// File: tb/tb_ram_16x8_ctrl.sv
// Bench for ram_16x8_ctrl: vector table, random VIEW traffic vs model,
// and timed sequences for debounce, scan, fill and reset-in-fill.
module tb_ram_16x8_ctrl;

  logic        clk;
  logic        clr;
  logic [7:0]  sw;
  logic [4:0]  btn;
  logic [15:0] x;
  logic        busy;

  ram_16x8_ctrl #(
    .DB_BITS  (2),
    .SCAN_BITS(4)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .sw      (sw),
    .btn_wr  (btn[0]),
    .btn_inc (btn[1]),
    .btn_dec (btn[2]),
    .btn_mode(btn[3]),
    .btn_fill(btn[4]),
    .x       (x),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_a;
  logic [7:0] m_mem [16];

  typedef struct {
    logic [4:0]  b;
    logic [7:0]  s;
    logic [15:0] ex;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int v,
                         input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s got %0d exp %0d..%0d", nm, v, lo, hi);
    end
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk);
    btn = m;
    repeat (10) @(negedge clk);
    btn = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic model_step(input logic [4:0] m, input logic [7:0] s);
    if (m[0])      m_mem[m_a] = s;
    else if (m[1]) m_a = m_a + 4'd1;
    else if (m[2]) m_a = m_a - 4'd1;
  endtask

  task automatic model_reset();
    m_a = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
  endtask

  task automatic readback_all(input string nm);
    for (int i = 0; i < 16; i++) begin
      press(5'b00010);
      m_a = m_a + 4'd1;
      chk(nm, x, {m_a, 4'h0, m_mem[m_a]});
    end
  endtask

  task automatic fill_run(input logic [7:0] s, input int wr_at);
    int first;
    int last;
    int nb;
    first = -1;
    last  = -1;
    nb    = 0;
    sw    = s;
    @(negedge clk);
    btn = (wr_at == 0) ? 5'b10001 : 5'b10000;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (busy) begin
        nb++;
        if (first < 0) first = k;
        last = k;
      end
      if (wr_at > 0 && k == wr_at) btn[0] = 1'b1;
      if (k == 10) btn[4] = 1'b0;
      if (k == wr_at + 10) btn[0] = 1'b0;
    end
    chk("busy_len", nb, 16);
    chk("busy_contig", last - first + 1, 16);
    chk_rng("busy_rise", first, 5, 8);
    for (int i = 0; i < 16; i++) m_mem[i] = s;
    chk("fill_x", x, {m_a, 4'h0, s});
    chk("fill_busy_end", busy, 0);
  endtask

  initial begin
    int n;
    int t;
    int phase;
    logic       seen;
    logic [3:0] nxt;
    logic [2:0] rm;
    logic [7:0] rs;

    tbl[0]  = '{5'b00010, 8'h00, 16'h1000};
    tbl[1]  = '{5'b00010, 8'h00, 16'h2000};
    tbl[2]  = '{5'b00010, 8'h00, 16'h3000};
    tbl[3]  = '{5'b00001, 8'hA5, 16'h30A5};
    tbl[4]  = '{5'b00100, 8'h00, 16'h2000};
    tbl[5]  = '{5'b00010, 8'h00, 16'h30A5};
    tbl[6]  = '{5'b00100, 8'h00, 16'h2000};
    tbl[7]  = '{5'b00100, 8'h00, 16'h1000};
    tbl[8]  = '{5'b00100, 8'h00, 16'h0000};
    tbl[9]  = '{5'b00100, 8'h00, 16'hF000};
    tbl[10] = '{5'b00010, 8'h00, 16'h0000};
    tbl[11] = '{5'b00011, 8'h5A, 16'h005A};
    tbl[12] = '{5'b00110, 8'h00, 16'h1000};
    tbl[13] = '{5'b00100, 8'h00, 16'h005A};
    tbl[14] = '{5'b00101, 8'h11, 16'h0011};
    tbl[15] = '{5'b00010, 8'h00, 16'h1000};

    clr = 1'b1;
    btn = '0;
    sw  = '0;
    #2 clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst_x", x, 16'h0000);
      chk("rst_busy", busy, 0);
      btn = 5'($urandom);
    end
    @(negedge clk);
    btn = '0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4) chk("idle_x", x, 16'h0000);
    end
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 16; i++) begin
      sw = tbl[i].s;
      press(tbl[i].b);
      model_step(tbl[i].b, tbl[i].s);
      chk($sformatf("tbl%0d", i), x, tbl[i].ex);
    end

    @(negedge clk);
    btn = 5'b00010;
    repeat (3) @(negedge clk);
    btn = '0;
    repeat (15) @(negedge clk);
    chk("glitch", x, {m_a, 4'h0, m_mem[m_a]});

    nxt = m_a + 4'd1;
    @(negedge clk);
    btn  = 5'b00010;
    n    = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (x[15:12] == nxt) seen = 1'b1;
    end
    chk("lat_seen", seen, 1);
    chk_rng("lat_cyc", n, 6, 8);
    repeat (3) @(negedge clk);
    btn = '0;
    repeat (15) @(negedge clk);
    m_a = nxt;
    chk("no_release_step", x, {m_a, 4'h0, m_mem[m_a]});

    for (int i = 0; i < 40; i++) begin
      rm = 3'($urandom_range(1, 7));
      rs = 8'($urandom);
      sw = rs;
      press({2'b00, rm});
      model_step({2'b00, rm}, rs);
      chk("rand", x, {m_a, 4'h0, m_mem[m_a]});
    end

    phase = 0;
    t     = 0;
    @(negedge clk);
    btn = 5'b01000;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (phase == 0) begin
        if (x[11:8] == 4'h5) begin
          phase = 1;
          t     = 0;
          chk("scan_entry", x, {m_a, 4'h5, m_mem[m_a]});
        end
      end else if (phase == 1) begin
        t++;
        if (x[11:8] != 4'h5) begin
          phase = 2;
          chk("scan_exit", x, {m_a, 4'h0, m_mem[m_a]});
        end else begin
          if (t % 16 == 0) m_a = m_a + 4'd1;
          chk("scan_step", x, {m_a, 4'h5, m_mem[m_a]});
        end
      end else begin
        chk("scan_hold", x, {m_a, 4'h0, m_mem[m_a]});
      end
      if (k == 10)  btn[3] = 1'b0;
      if (k == 25)  btn[1] = 1'b1;
      if (k == 36)  btn[1] = 1'b0;
      if (k == 100) btn[3] = 1'b1;
      if (k == 110) btn[3] = 1'b0;
    end
    chk("scan_done", phase, 2);

    fill_run(8'h3C, 0);
    readback_all("fill1_rd");
    fill_run(8'hC3, 3);
    readback_all("fill2_rd");

    sw = 8'hE7;
    @(negedge clk);
    btn = 5'b10000;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midfill_busy", busy, 1);
    repeat (4) @(negedge clk);
    clr = 1'b0;
    btn = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midfill_rst_x", x, 16'h0000);
      chk("midfill_rst_busy", busy, 0);
    end
    clr = 1'b1;
    model_reset();
    repeat (15) @(negedge clk);
    chk("midfill_after", x, 16'h0000);
    readback_all("midfill_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
